// File: rtl/funct_gen_pipe_pkg.sv
// Shared constants for the multi-lane ALU funct generator: opcode and
// REGIMM rt encodings, ALU FUNCT codes and default field widths.
package funct_gen_pipe_pkg;

    // Default per-lane field widths
    localparam int OP_W_DEF    = 6;
    localparam int FUNCT_W_DEF = 6;
    localparam int RT_W_DEF    = 5;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // REGIMM rt sub-opcodes
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // ALU FUNCT codes
    localparam logic [5:0] FUNCT_NOP  = 6'b000000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/funct_gen_pipe_if.sv
// Bundle of the input-side and output-side beat handshakes of the funct
// generator. The block itself connects through the slave modport.
//
// Handshake rule (both sides): a beat transfers on a rising clock edge where
// valid and ready are both 1. A source holding valid=1 keeps its payload
// stable until the transfer; valid never waits on ready. in_ready is a pure
// register output and never depends on out_ready in the same cycle.
interface funct_gen_pipe_if #(
    parameter int LANES   = 2,
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int RT_W    = 5
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0]         in_lane_mask;
    logic [LANES*OP_W-1:0]    in_op;
    logic [LANES*FUNCT_W-1:0] in_funct;
    logic [LANES*RT_W-1:0]    in_rt;

    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0]         out_lane_mask;
    logic [LANES*FUNCT_W-1:0] out_funct;
    logic [LANES-1:0]         out_link;
    logic [LANES-1:0]         out_reserved;

    modport slave (
        input  in_valid, in_lane_mask, in_op, in_funct, in_rt, out_ready,
        output in_ready, out_valid, out_lane_mask, out_funct, out_link, out_reserved
    );

    modport master (
        output in_valid, in_lane_mask, in_op, in_funct, in_rt, out_ready,
        input  in_ready, out_valid, out_lane_mask, out_funct, out_link, out_reserved
    );
endinterface

// File: rtl/funct_lane_dec.sv
// Single-lane combinational decoder: instruction op/funct/rt to ALU FUNCT
// code, plus link (JAL/BLTZAL/BGEZAL) and reserved-instruction flags.
module funct_lane_dec
    import funct_gen_pipe_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int FUNCT_W = FUNCT_W_DEF,
    parameter int RT_W    = RT_W_DEF
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic [RT_W-1:0]    rt,
    input  logic               lane_en,
    output logic [FUNCT_W-1:0] funct,
    output logic               link,
    output logic               reserved
);

    // Decode table; a disabled lane always reads as a plain NOP
    always_comb begin
        funct    = FUNCT_W'(FUNCT_NOP);
        link     = 1'b0;
        reserved = 1'b0;
        if (lane_en) begin
            case (op)
                OP_W'(OP_SPECIAL): funct = funct_in;
                OP_W'(OP_ORI),
                OP_W'(OP_LUI):     funct = FUNCT_W'(FUNCT_OR);
                OP_W'(OP_JAL): begin
                    funct = FUNCT_W'(FUNCT_OR);
                    link  = 1'b1;
                end
                OP_W'(OP_ANDI):    funct = FUNCT_W'(FUNCT_AND);
                OP_W'(OP_XORI):    funct = FUNCT_W'(FUNCT_XOR);
                OP_W'(OP_LB),
                OP_W'(OP_LBU),
                OP_W'(OP_LH),
                OP_W'(OP_LHU),
                OP_W'(OP_LW),
                OP_W'(OP_SB),
                OP_W'(OP_SH),
                OP_W'(OP_SW),
                OP_W'(OP_ADDI):    funct = FUNCT_W'(FUNCT_ADD);
                OP_W'(OP_ADDIU):   funct = FUNCT_W'(FUNCT_ADDU);
                OP_W'(OP_SLTI):    funct = FUNCT_W'(FUNCT_SLT);
                OP_W'(OP_SLTIU):   funct = FUNCT_W'(FUNCT_SLTU);
                OP_W'(OP_REGIMM): begin
                    case (rt)
                        RT_W'(RT_BLTZAL),
                        RT_W'(RT_BGEZAL): begin
                            funct = FUNCT_W'(FUNCT_OR);
                            link  = 1'b1;
                        end
                        RT_W'(RT_BLTZ),
                        RT_W'(RT_BGEZ):   funct = FUNCT_W'(FUNCT_NOP);
                        default:          reserved = 1'b1;
                    endcase
                end
                OP_W'(OP_J),
                OP_W'(OP_BEQ),
                OP_W'(OP_BNE),
                OP_W'(OP_BLEZ),
                OP_W'(OP_BGTZ):    funct = FUNCT_W'(FUNCT_NOP);
                default:           reserved = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/funct_gen_pipe.sv
// Multi-lane registered ALU funct generator. Decodes up to LANES instructions
// per beat and holds results in a main register (M) backed by a one-entry
// skid register (S), so in_ready comes straight from a flop.
module funct_gen_pipe
    import funct_gen_pipe_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int OP_W    = OP_W_DEF,
    parameter int FUNCT_W = FUNCT_W_DEF,
    parameter int RT_W    = RT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    funct_gen_pipe_if.slave      bus
);

    localparam int FW = LANES * FUNCT_W;

    // Decoded view of the beat currently offered on the input
    logic [LANES-1:0] dec_link;
    logic [LANES-1:0] dec_res;
    logic [FW-1:0]    dec_funct;

    // Main (M) and skid (S) registers with their next-state values
    logic             m_valid, m_valid_nxt;
    logic [LANES-1:0] m_mask,  m_mask_nxt;
    logic [FW-1:0]    m_funct, m_funct_nxt;
    logic [LANES-1:0] m_link,  m_link_nxt;
    logic [LANES-1:0] m_res,   m_res_nxt;

    logic             s_valid, s_valid_nxt;
    logic [LANES-1:0] s_mask,  s_mask_nxt;
    logic [FW-1:0]    s_funct, s_funct_nxt;
    logic [LANES-1:0] s_link,  s_link_nxt;
    logic [LANES-1:0] s_res,   s_res_nxt;

    logic             in_ready_q;
    logic             accept;
    logic             pop;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        funct_lane_dec #(
            .OP_W    (OP_W),
            .FUNCT_W (FUNCT_W),
            .RT_W    (RT_W)
        ) u_dec (
            .op       (bus.in_op[g*OP_W +: OP_W]),
            .funct_in (bus.in_funct[g*FUNCT_W +: FUNCT_W]),
            .rt       (bus.in_rt[g*RT_W +: RT_W]),
            .lane_en  (bus.in_lane_mask[g]),
            .funct    (dec_funct[g*FUNCT_W +: FUNCT_W]),
            .link     (dec_link[g]),
            .reserved (dec_res[g])
        );
    end

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = m_valid & bus.out_ready;

    // Next-state for M/S: flush, then pop (refill from S or input), then fill
    always_comb begin
        m_valid_nxt = m_valid;
        m_mask_nxt  = m_mask;
        m_funct_nxt = m_funct;
        m_link_nxt  = m_link;
        m_res_nxt   = m_res;
        s_valid_nxt = s_valid;
        s_mask_nxt  = s_mask;
        s_funct_nxt = s_funct;
        s_link_nxt  = s_link;
        s_res_nxt   = s_res;

        if (flush) begin
            // Everything buffered is discarded, including a concurrent accept
            m_valid_nxt = 1'b0;
            m_mask_nxt  = '0;
            m_funct_nxt = '0;
            m_link_nxt  = '0;
            m_res_nxt   = '0;
            s_valid_nxt = 1'b0;
            s_mask_nxt  = '0;
            s_funct_nxt = '0;
            s_link_nxt  = '0;
            s_res_nxt   = '0;
        end else if (pop && s_valid) begin
            // in_ready is low whenever S is full, so no accept can collide here
            m_valid_nxt = 1'b1;
            m_mask_nxt  = s_mask;
            m_funct_nxt = s_funct;
            m_link_nxt  = s_link;
            m_res_nxt   = s_res;
            s_valid_nxt = 1'b0;
        end else if (pop || !m_valid) begin
            // M is (or becomes) free: take the incoming beat if there is one
            if (accept) begin
                m_valid_nxt = 1'b1;
                m_mask_nxt  = bus.in_lane_mask;
                m_funct_nxt = dec_funct;
                m_link_nxt  = dec_link;
                m_res_nxt   = dec_res;
            end else begin
                m_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            // M is stalled: park the beat in the skid register
            s_valid_nxt = 1'b1;
            s_mask_nxt  = bus.in_lane_mask;
            s_funct_nxt = dec_funct;
            s_link_nxt  = dec_link;
            s_res_nxt   = dec_res;
        end
    end

    // State registers; in_ready is precomputed from the next skid occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_mask     <= '0;
            m_funct    <= '0;
            m_link     <= '0;
            m_res      <= '0;
            s_valid    <= 1'b0;
            s_mask     <= '0;
            s_funct    <= '0;
            s_link     <= '0;
            s_res      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid    <= m_valid_nxt;
            m_mask     <= m_mask_nxt;
            m_funct    <= m_funct_nxt;
            m_link     <= m_link_nxt;
            m_res      <= m_res_nxt;
            s_valid    <= s_valid_nxt;
            s_mask     <= s_mask_nxt;
            s_funct    <= s_funct_nxt;
            s_link     <= s_link_nxt;
            s_res      <= s_res_nxt;
            in_ready_q <= ~s_valid_nxt;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = m_valid;
    assign bus.out_lane_mask = m_mask;
    assign bus.out_funct     = m_funct;
    assign bus.out_link      = m_link;
    assign bus.out_reserved  = m_res;

endmodule

// File: tb/tb_funct_gen_pipe.sv
// Directed self-checking bench for funct_gen_pipe with LANES=2.
module tb_funct_gen_pipe;
    import funct_gen_pipe_pkg::*;

    localparam int LANES = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    logic [11:0] exp_q[$];

    funct_gen_pipe_if #(.LANES(LANES)) bus ();

    funct_gen_pipe #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Back-to-back vector table: lane0 funct field is always 6'h3f (ignored
    // unless SPECIAL), rt fields default to 5'h11 (ignored unless REGIMM).
    localparam logic [5:0]  T_OP0  [8] = '{6'b001100, 6'b100011, 6'b001010, 6'b000100,
                                           6'b000011, 6'b000001, 6'b000001, 6'b000010};
    localparam logic [4:0]  T_RT0  [8] = '{5'h11, 5'h11, 5'h11, 5'h11,
                                           5'h11, 5'b00010, 5'b10000, 5'h11};
    localparam logic [5:0]  T_OP1  [8] = '{6'b001110, 6'b001001, 6'b001011, 6'b000001,
                                           6'b001111, 6'b101011, 6'b101000, 6'b000000};
    localparam logic [4:0]  T_RT1  [8] = '{5'h11, 5'h11, 5'h11, 5'b00000,
                                           5'h11, 5'h11, 5'h11, 5'h11};
    localparam logic [5:0]  T_F1   [8] = '{6'h3f, 6'h3f, 6'h3f, 6'h3f,
                                           6'h3f, 6'h3f, 6'h3f, 6'b101010};
    localparam logic [11:0] T_EXPF [8] = '{{6'b100110, 6'b100100}, {6'b100001, 6'b100000},
                                           {6'b101011, 6'b101010}, {6'b000000, 6'b000000},
                                           {6'b100101, 6'b100101}, {6'b100000, 6'b000000},
                                           {6'b100000, 6'b100101}, {6'b101010, 6'b000000}};
    localparam logic [1:0]  T_LINK [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    localparam logic [1:0]  T_RES  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [1:0] mask,
                              input logic [5:0] op0, input logic [5:0] f0, input logic [4:0] rt0,
                              input logic [5:0] op1, input logic [5:0] f1, input logic [4:0] rt1);
        bus.in_valid     = 1'b1;
        bus.in_lane_mask = mask;
        bus.in_op        = {op1, op0};
        bus.in_funct     = {f1, f0};
        bus.in_rt        = {rt1, rt0};
    endtask

    task automatic drive_idle();
        bus.in_valid     = 1'b0;
        bus.in_lane_mask = '0;
        bus.in_op        = '0;
        bus.in_funct     = '0;
        bus.in_rt        = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_lane_mask !== 2'b00) begin failures++; $display("FAIL reset_mask got=%b exp=00", bus.out_lane_mask); end
        checks++; if (bus.out_funct !== 12'h000) begin failures++; $display("FAIL reset_funct got=%b exp=0", bus.out_funct); end
        checks++; if (bus.out_link !== 2'b00) begin failures++; $display("FAIL reset_link got=%b exp=00", bus.out_link); end
        checks++; if (bus.out_reserved !== 2'b00) begin failures++; $display("FAIL reset_reserved got=%b exp=00", bus.out_reserved); end
    endtask

    task automatic test_ori_special();
        bus.out_ready = 1'b1;
        drive_beat(2'b11, 6'b001101, 6'h3f, 5'h00, 6'b000000, 6'b100011, 5'h00);
        tick();
        drive_idle();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ori_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_funct !== {6'b100011, 6'b100101}) begin failures++; $display("FAIL ori_funct got=%b exp=%b", bus.out_funct, {6'b100011, 6'b100101}); end
        checks++; if (bus.out_reserved !== 2'b00) begin failures++; $display("FAIL ori_reserved got=%b exp=00", bus.out_reserved); end
        checks++; if (bus.out_link !== 2'b00) begin failures++; $display("FAIL ori_link got=%b exp=00", bus.out_link); end
        checks++; if (bus.out_lane_mask !== 2'b11) begin failures++; $display("FAIL ori_mask got=%b exp=11", bus.out_lane_mask); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ori_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_regimm_reserved();
        bus.out_ready = 1'b1;
        drive_beat(2'b11, 6'b000001, 6'h00, 5'b10001, 6'b111111, 6'h25, 5'h00);
        tick();
        drive_idle();
        checks++; if (bus.out_funct !== {6'b000000, 6'b100101}) begin failures++; $display("FAIL regimm_funct got=%b exp=%b", bus.out_funct, {6'b000000, 6'b100101}); end
        checks++; if (bus.out_link !== 2'b01) begin failures++; $display("FAIL regimm_link got=%b exp=01", bus.out_link); end
        checks++; if (bus.out_reserved !== 2'b10) begin failures++; $display("FAIL regimm_reserved got=%b exp=10", bus.out_reserved); end
        tick();
    endtask

    task automatic test_mask();
        bus.out_ready = 1'b1;
        drive_beat(2'b01, 6'b001000, 6'h3f, 5'h11, 6'b111111, 6'h2a, 5'h11);
        tick();
        drive_idle();
        checks++; if (bus.out_lane_mask !== 2'b01) begin failures++; $display("FAIL mask_mask got=%b exp=01", bus.out_lane_mask); end
        checks++; if (bus.out_reserved !== 2'b00) begin failures++; $display("FAIL mask_reserved got=%b exp=00", bus.out_reserved); end
        checks++; if (bus.out_funct !== {6'b000000, 6'b100000}) begin failures++; $display("FAIL mask_funct got=%b exp=%b", bus.out_funct, {6'b000000, 6'b100000}); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_beat(2'b11, T_OP0[i], 6'h3f, T_RT0[i], T_OP1[i], T_F1[i], T_RT1[i]);
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.out_funct !== T_EXPF[i]) begin failures++; $display("FAIL b2b_funct[%0d] got=%b exp=%b", i, bus.out_funct, T_EXPF[i]); end
            checks++; if (bus.out_link !== T_LINK[i]) begin failures++; $display("FAIL b2b_link[%0d] got=%b exp=%b", i, bus.out_link, T_LINK[i]); end
            checks++; if (bus.out_reserved !== T_RES[i]) begin failures++; $display("FAIL b2b_reserved[%0d] got=%b exp=%b", i, bus.out_reserved, T_RES[i]); end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
        end
        drive_idle();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_stall();
        logic [11:0] exp;
        bus.out_ready = 1'b0;
        // A: ORI / ANDI
        drive_beat(2'b11, 6'b001101, 6'h3f, 5'h11, 6'b001100, 6'h3f, 5'h11);
        exp_q.push_back({6'b100100, 6'b100101});
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_a got=%b exp=1", bus.in_ready); end
        // B: XORI / ADDIU
        drive_beat(2'b11, 6'b001110, 6'h3f, 5'h11, 6'b001001, 6'h3f, 5'h11);
        exp_q.push_back({6'b100001, 6'b100110});
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_b got=%b exp=0", bus.in_ready); end
        // C: SLTI / SLTIU, offered while the skid is full
        drive_beat(2'b11, 6'b001010, 6'h3f, 5'h11, 6'b001011, 6'h3f, 5'h11);
        exp_q.push_back({6'b101011, 6'b101010});
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_c got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid got=%b exp=1", bus.out_valid); end
        exp = exp_q.pop_front();
        checks++; if (bus.out_funct !== exp) begin failures++; $display("FAIL stall_hold_a got=%b exp=%b", bus.out_funct, exp); end
        // Release: B must follow A with no bubble, then C
        bus.out_ready = 1'b1;
        tick();
        exp = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_b_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_funct !== exp) begin failures++; $display("FAIL stall_b_funct got=%b exp=%b", bus.out_funct, exp); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_after got=%b exp=1", bus.in_ready); end
        tick();
        drive_idle();
        exp = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_c_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_funct !== exp) begin failures++; $display("FAIL stall_c_funct got=%b exp=%b", bus.out_funct, exp); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive_beat(2'b11, 6'b001101, 6'h3f, 5'h11, 6'b001101, 6'h3f, 5'h11);
        tick();
        drive_beat(2'b11, 6'b001000, 6'h3f, 5'h11, 6'b001000, 6'h3f, 5'h11);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", bus.in_ready); end
        drive_beat(2'b11, 6'b001100, 6'h3f, 5'h11, 6'b001100, 6'h3f, 5'h11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_idle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_funct !== 12'h000) begin failures++; $display("FAIL flush_funct got=%b exp=0", bus.out_funct); end
        checks++; if (bus.out_lane_mask !== 2'b00) begin failures++; $display("FAIL flush_mask got=%b exp=00", bus.out_lane_mask); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d] got=%b exp=0", i, bus.out_valid); end
        end
        // Pipe still works after a flush
        drive_beat(2'b11, 6'b001011, 6'h3f, 5'h11, 6'b000011, 6'h3f, 5'h11);
        tick();
        drive_idle();
        checks++; if (bus.out_funct !== {6'b100101, 6'b101011}) begin failures++; $display("FAIL flush_after_funct got=%b exp=%b", bus.out_funct, {6'b100101, 6'b101011}); end
        checks++; if (bus.out_link !== 2'b10) begin failures++; $display("FAIL flush_after_link got=%b exp=10", bus.out_link); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ori_special();
        test_regimm_reserved();
        test_mask();
        test_back_to_back();
        test_stall();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
